// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the decode stage.
// Optional statistics are enabled by defining HAZARD_STATS_EN.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RST_WAIT   = 2'd0,
      RUN        = 2'd1,
      LOAD_STALL = 2'd2,
      DIV_WAIT   = 2'd3
   } hz_state_t;

   localparam int REG_W_DEFAULT = 4;

   // Instruction class the decode stage treats as a bubble.
   localparam logic [4:0] NOP_CLASS = 5'b00000;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter with a zero flag, shared by load-use and divide stalls.
module stall_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // A load always wins over a decrement, and the count parks at zero rather
   // than wrapping so a stray decrement can never create a phantom stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the fetch and decode buffers: load-use, divide, branch.
// Define HAZARD_STATS_EN to add saturating event counters on extra output ports.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_W             = REG_W_DEFAULT,
   parameter int DIV_CYCLES        = 8,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_ra,
   input  logic [REG_W-1:0] id_rb,
   input  logic             id_uses_ra,
   input  logic             id_uses_rb,
   input  logic             ex_valid,
   input  logic             ex_is_load,
   input  logic             ex_is_div,
   input  logic             ex_writes,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             if_flush,
   output logic             id_flush,
   output logic             ex_hold,
   output logic             busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_load_stalls,
   output logic [CNT_W-1:0] stat_div_cycles,
   output logic [CNT_W-1:0] stat_flushes
`endif
);

   localparam int STALL_W = (maxInt(DIV_CYCLES, LOAD_STALL_CYCLES) > 1)
                            ? $clog2(maxInt(DIV_CYCLES, LOAD_STALL_CYCLES)) : 1;

   hz_state_t        state;
   hz_state_t        nextState;
   logic [STALL_W-1:0] stallCnt;
   logic             stallZero;
   logic             cntLoad;
   logic [STALL_W-1:0] cntLoadValue;
   logic             cntDec;
   logic             divStart;
   logic             loadUse;
   logic             loadBubble;
   logic             branchFlush;

   // Raw event detection; priority between them is resolved in the FSM below.
   // Register 0 is deliberately treated like any other register.
   always_comb begin
      divStart = ex_valid && ex_is_div;
      loadUse  = ex_valid && ex_is_load && ex_writes && id_valid &&
                 ((id_uses_ra && (id_ra == ex_rd)) ||
                  (id_uses_rb && (id_rb == ex_rd)));
   end

   stall_counter #(
      .W(STALL_W)
   ) u_stall_counter (
      .clk        (clk),
      .rst        (rst),
      .load       (cntLoad),
      .load_value (cntLoadValue),
      .dec        (cntDec),
      .count      (stallCnt),
      .zero       (stallZero)
   );

   // State register only; all controls are decoded combinationally from it so
   // that an asserted reset forces the reset outputs without waiting for a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RST_WAIT;
      end else begin
         state <= nextState;
      end
   end

   // Mealy output and next-state decode. In RUN a taken branch beats a divide,
   // which beats a load-use hazard. The RUN cycle that sees the divide is its
   // first hold cycle, and the DIV_WAIT cycle at count 0 is its last, so the
   // divide occupies EX for exactly DIV_CYCLES cycles (DIV_CYCLES=2 still
   // passes through DIV_WAIT once). The RUN bubble is the first of the
   // LOAD_STALL_CYCLES load-use bubbles.
   always_comb begin
      nextState    = state;
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      if_flush     = 1'b1;
      id_flush     = 1'b1;
      ex_hold      = 1'b0;
      cntLoad      = 1'b0;
      cntLoadValue = '0;
      cntDec       = 1'b0;
      loadBubble   = 1'b0;
      branchFlush  = 1'b0;
      case (state)
         RST_WAIT: begin
            nextState = RUN;
         end
         RUN: begin
            fetch_en  = 1'b1;
            decode_en = 1'b1;
            if_flush  = 1'b0;
            id_flush  = 1'b0;
            if (ex_branch_taken) begin
               if_flush    = 1'b1;
               id_flush    = 1'b1;
               branchFlush = 1'b1;
            end else if (divStart) begin
               fetch_en     = 1'b0;
               decode_en    = 1'b0;
               ex_hold      = 1'b1;
               cntLoad      = 1'b1;
               cntLoadValue = STALL_W'(DIV_CYCLES - 2);
               nextState    = DIV_WAIT;
            end else if (loadUse) begin
               fetch_en     = 1'b0;
               decode_en    = 1'b0;
               id_flush     = 1'b1;
               loadBubble   = 1'b1;
               cntLoad      = 1'b1;
               cntLoadValue = STALL_W'(LOAD_STALL_CYCLES - 1);
               if (LOAD_STALL_CYCLES > 1) begin
                  nextState = LOAD_STALL;
               end
            end
         end
         DIV_WAIT: begin
            if_flush = 1'b0;
            id_flush = 1'b0;
            ex_hold  = 1'b1;
            cntDec   = 1'b1;
            if (stallZero) begin
               nextState = RUN;
            end
         end
         LOAD_STALL: begin
            if_flush   = 1'b0;
            loadBubble = 1'b1;
            cntDec     = 1'b1;
            if (stallCnt <= STALL_W'(1)) begin
               nextState = RUN;
            end
         end
         default: begin
            nextState = RST_WAIT;
         end
      endcase
   end

   assign busy = (state != RUN);

`ifdef HAZARD_STATS_EN
   // Event counters saturate at all-ones instead of wrapping so long runs
   // still report a meaningful (if clipped) figure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_load_stalls <= '0;
         stat_div_cycles  <= '0;
         stat_flushes     <= '0;
      end else begin
         if (loadBubble && (stat_load_stalls != '1)) begin
            stat_load_stalls <= stat_load_stalls + CNT_W'(1);
         end
         if (ex_hold && (stat_div_cycles != '1)) begin
            stat_div_cycles <= stat_div_cycles + CNT_W'(1);
         end
         if (branchFlush && (stat_flushes != '1)) begin
            stat_flushes <= stat_flushes + CNT_W'(1);
         end
      end
   end
`endif

endmodule
